// File: rtl/sample_fetch.sv
// Sample ROM byte reader with a current-line and a next-line buffer over a toggle-handshake SDRAM port.
// Latency: hits return one edge after rd_strobe; misses return on the SDRAM ack edge. Strobes are dropped while rd_busy=1.
module sample_fetch #(
    parameter logic [21:0] BASE_WORD = 22'h000000
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        rd_strobe,
    input  logic [17:0] rd_addr,
    input  logic        flush,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_busy,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic [21:0] sdr_addr,
    input  logic [63:0] sdr_q
);

    typedef enum logic [2:0] {SYNC, IDLE, DEMAND, PREFETCH, DRAIN} state_t;

    state_t       state_q, state_d;
    logic         sdr_req_q, sdr_req_d;
    logic [21:0]  sdr_addr_q, sdr_addr_d;
    logic [14:0]  fetch_tag_q, fetch_tag_d;
    logic         cur_vld_q, cur_vld_d, pre_vld_q, pre_vld_d;
    logic [14:0]  cur_tag_q, cur_tag_d, pre_tag_q, pre_tag_d;
    logic [63:0]  cur_dat_q, cur_dat_d, pre_dat_q, pre_dat_d;
    logic [17:0]  lat_addr_q, lat_addr_d;
    logic         pf_pend_q, pf_pend_d;
    logic         drop_q, drop_d;
    logic [7:0]   rd_data_q, rd_data_d;
    logic         rd_valid_q, rd_valid_d, rd_busy_q, rd_busy_d;

    logic         accept, acked, discard, cur_hit_in, pre_hit_in;
    logic [14:0]  rd_tag;
    logic         res_en, iss_en;
    logic [17:0]  res_addr;
    logic [14:0]  iss_tag;

    function automatic logic [7:0] pick(input logic [63:0] line, input logic [2:0] n);
        return line[{n, 3'b000} +: 8];
    endfunction

    function automatic logic [21:0] line_addr(input logic [14:0] t);
        return BASE_WORD + {5'd0, t, 2'b00};
    endfunction

    assign rd_tag     = rd_addr[17:3];
    assign accept     = rd_strobe && !rd_busy_q;
    assign acked      = (sdr_ack == sdr_req_q);
    assign discard    = drop_q || flush;
    assign cur_hit_in = cur_vld_q && !flush && (cur_tag_q == rd_tag);
    assign pre_hit_in = pre_vld_q && !flush && (pre_tag_q == rd_tag) && !cur_hit_in;

    always_comb begin
        state_d     = state_q;
        sdr_req_d   = sdr_req_q;
        sdr_addr_d  = sdr_addr_q;
        fetch_tag_d = fetch_tag_q;
        cur_vld_d   = cur_vld_q && !flush;
        pre_vld_d   = pre_vld_q && !flush;
        cur_tag_d   = cur_tag_q;
        pre_tag_d   = pre_tag_q;
        cur_dat_d   = cur_dat_q;
        pre_dat_d   = pre_dat_q;
        lat_addr_d  = lat_addr_q;
        pf_pend_d   = pf_pend_q;
        drop_d      = drop_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rd_busy_d   = rd_busy_q;
        res_en      = 1'b0;
        res_addr    = lat_addr_q;
        iss_en      = 1'b0;
        iss_tag     = fetch_tag_q;

        case (state_q)
            SYNC: begin
                if (accept) begin
                    lat_addr_d = rd_addr;
                    rd_busy_d  = 1'b1;
                end
                if (acked) begin
                    if (rd_busy_q || accept) begin
                        iss_en     = 1'b1;
                        iss_tag    = accept ? rd_tag : lat_addr_q[17:3];
                        rd_busy_d  = 1'b1;
                        state_d    = DEMAND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                pf_pend_d = 1'b0;
                if (pf_pend_q && !flush) begin
                    // Deferred next-line prefetch; a strobe here behaves as one arriving in PREFETCH.
                    iss_en  = 1'b1;
                    iss_tag = cur_tag_q + 15'd1;
                    state_d = PREFETCH;
                    if (accept) begin
                        if (cur_hit_in) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = pick(cur_dat_q, rd_addr[2:0]);
                        end else begin
                            lat_addr_d = rd_addr;
                            rd_busy_d  = 1'b1;
                            state_d    = DRAIN;
                        end
                    end
                end else if (accept) begin
                    if (cur_hit_in) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = pick(cur_dat_q, rd_addr[2:0]);
                    end else if (pre_hit_in) begin
                        cur_dat_d  = pre_dat_q;
                        cur_tag_d  = pre_tag_q;
                        cur_vld_d  = 1'b1;
                        pre_vld_d  = 1'b0;
                        rd_valid_d = 1'b1;
                        rd_data_d  = pick(pre_dat_q, rd_addr[2:0]);
                        pf_pend_d  = 1'b1;
                    end else begin
                        iss_en     = 1'b1;
                        iss_tag    = rd_tag;
                        lat_addr_d = rd_addr;
                        rd_busy_d  = 1'b1;
                        state_d    = DEMAND;
                    end
                end
            end
            DEMAND: begin
                if (flush) drop_d = 1'b1;
                if (acked) begin
                    drop_d = 1'b0;
                    if (discard) begin
                        iss_en  = 1'b1;
                        iss_tag = fetch_tag_q;
                    end else begin
                        cur_dat_d  = sdr_q;
                        cur_tag_d  = fetch_tag_q;
                        cur_vld_d  = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_data_d  = pick(sdr_q, lat_addr_q[2:0]);
                        rd_busy_d  = 1'b0;
                        pf_pend_d  = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            PREFETCH, DRAIN: begin
                if (flush) drop_d = 1'b1;
                if (acked) begin
                    drop_d  = 1'b0;
                    state_d = IDLE;
                    if (!discard) begin
                        pre_dat_d = sdr_q;
                        pre_tag_d = fetch_tag_q;
                        pre_vld_d = 1'b1;
                    end
                    if (state_q == DRAIN) begin
                        res_en = 1'b1;
                    end else if (accept) begin
                        res_en   = 1'b1;
                        res_addr = rd_addr;
                    end
                end else if (state_q == PREFETCH && accept) begin
                    if (cur_hit_in) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = pick(cur_dat_q, rd_addr[2:0]);
                    end else begin
                        lat_addr_d = rd_addr;
                        rd_busy_d  = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            default: state_d = SYNC;
        endcase

        // Re-evaluate a waiting address against CUR and the line that just landed.
        if (res_en) begin
            if (cur_vld_q && !flush && cur_tag_q == res_addr[17:3]) begin
                rd_valid_d = 1'b1;
                rd_data_d  = pick(cur_dat_q, res_addr[2:0]);
                rd_busy_d  = 1'b0;
                state_d    = IDLE;
            end else if (!discard && fetch_tag_q == res_addr[17:3]) begin
                cur_dat_d  = sdr_q;
                cur_tag_d  = fetch_tag_q;
                cur_vld_d  = 1'b1;
                pre_vld_d  = 1'b0;
                rd_valid_d = 1'b1;
                rd_data_d  = pick(sdr_q, res_addr[2:0]);
                rd_busy_d  = 1'b0;
                pf_pend_d  = 1'b1;
                state_d    = IDLE;
            end else begin
                iss_en     = 1'b1;
                iss_tag    = res_addr[17:3];
                lat_addr_d = res_addr;
                rd_busy_d  = 1'b1;
                state_d    = DEMAND;
            end
        end

        if (iss_en) begin
            sdr_req_d   = ~sdr_req_q;
            sdr_addr_d  = line_addr(iss_tag);
            fetch_tag_d = iss_tag;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q     <= SYNC;
            sdr_req_q   <= 1'b0;
            sdr_addr_q  <= '0;
            fetch_tag_q <= '0;
            cur_vld_q   <= 1'b0;
            pre_vld_q   <= 1'b0;
            cur_tag_q   <= '0;
            pre_tag_q   <= '0;
            cur_dat_q   <= '0;
            pre_dat_q   <= '0;
            lat_addr_q  <= '0;
            pf_pend_q   <= 1'b0;
            drop_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sdr_req_q   <= sdr_req_d;
            sdr_addr_q  <= sdr_addr_d;
            fetch_tag_q <= fetch_tag_d;
            cur_vld_q   <= cur_vld_d;
            pre_vld_q   <= pre_vld_d;
            cur_tag_q   <= cur_tag_d;
            pre_tag_q   <= pre_tag_d;
            cur_dat_q   <= cur_dat_d;
            pre_dat_q   <= pre_dat_d;
            lat_addr_q  <= lat_addr_d;
            pf_pend_q   <= pf_pend_d;
            drop_q      <= drop_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_busy_q   <= rd_busy_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_busy  = rd_busy_q;
    assign sdr_req  = sdr_req_q;
    assign sdr_addr = sdr_addr_q;

endmodule

// File: tb/tb_sample_fetch.sv
// Scoreboarded bench for sample_fetch: SDRAM toggle responder with a pattern memory, expected bytes queued per accepted strobe.
module tb_sample_fetch;

    logic        clk = 1'b0;
    logic        init_n;
    logic        rd_strobe, flush;
    logic [17:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_busy, sdr_req, sdr_ack;
    logic [21:0] sdr_addr;
    logic [63:0] sdr_q;

    int          checks = 0;
    int          errors = 0;
    int          ack_lat = 3;
    bit          resp_en = 1'b0;
    int          cyc = 0;
    int          strobe_cyc = 0;
    int          last_valid_cyc = 0;
    int          last_valid_reqs = 0;
    int          n_valid = 0;
    int          n_acc = 0;
    logic [7:0]  exp_q[$];
    logic [21:0] req_log[$];

    sample_fetch #(.BASE_WORD(22'h100000)) dut (
        .clk(clk), .init_n(init_n), .rd_strobe(rd_strobe), .rd_addr(rd_addr), .flush(flush),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
        .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_addr(sdr_addr), .sdr_q(sdr_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_line(input logic [21:0] a);
        if (a == 22'h100008) return 64'h8877_6655_4433_2211;
        return {a[15:0] ^ 16'h5A3C, ~a[15:0], a[15:0] + 16'h1234, a[15:0] ^ 16'hC0FE};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [17:0] ra);
        logic [21:0] w;
        logic [63:0] l;
        int          idx;
        w   = 22'h100000 + {5'd0, ra[17:3], 2'b00};
        l   = mem_line(w);
        idx = int'(ra[2:0]);
        return l[idx*8 +: 8];
    endfunction

    // SDRAM controller model: logs each request address and acks after ack_lat cycles.
    initial begin
        logic [21:0] a;
        sdr_ack = 1'b0;
        sdr_q   = '0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && (sdr_req !== sdr_ack)) begin
                a = sdr_addr;
                req_log.push_back(a);
                repeat (ack_lat - 1) @(posedge clk);
                #1;
                sdr_q   = mem_line(a);
                sdr_ack = sdr_req;
                @(posedge clk); #1;
                sdr_q   = ~mem_line(a);
            end
        end
    end

    always @(negedge clk) begin
        if (init_n && rd_valid) begin
            n_valid++;
            last_valid_cyc  = cyc;
            last_valid_reqs = req_log.size();
            if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
            else chk("rd_data", rd_data, exp_q.pop_front());
        end
    end

    task automatic strobe(input logic [17:0] a, input logic [7:0] e, input bit acc, input bit fl);
        @(negedge clk);
        rd_strobe  = 1'b1;
        rd_addr    = a;
        flush      = fl;
        strobe_cyc = cyc;
        if (acc) begin
            exp_q.push_back(e);
            n_acc++;
        end
        @(negedge clk);
        rd_strobe = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 4; i++) begin
            @(negedge clk);
            if (sdr_req === sdr_ack && rd_busy === 1'b0 && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        init_n = 1'b0; rd_strobe = 1'b0; rd_addr = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sdr_req", sdr_req, 0);
        chk("rst_sdr_addr", sdr_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_busy", rd_busy, 0);
        init_n = 1'b1;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);

        // Cold miss, 9-cycle ack
        ack_lat = 9;
        n = req_log.size();
        strobe(18'h00013, 8'h44, 1, 0);
        chk("miss_busy", rd_busy, 1);
        wait_idle("cold");
        chk("cold_nreq", req_log.size(), n + 2);
        chk("cold_dem_addr", req_log[n], 22'h100008);
        chk("cold_pf_addr", req_log[n+1], 22'h10000C);

        // CUR hit then PRE hit
        ack_lat = 3;
        n = req_log.size();
        strobe(18'h00014, 8'h55, 1, 0);
        repeat (3) @(negedge clk);
        chk("hit_lat", last_valid_cyc - strobe_cyc, 1);
        chk("hit_noreq", req_log.size(), n);
        strobe(18'h0001A, exp_byte(18'h0001A), 1, 0);
        repeat (2) @(negedge clk);
        chk("prehit_lat", last_valid_cyc - strobe_cyc, 1);
        wait_idle("prehit");
        chk("prehit_nreq", req_log.size(), n + 1);
        chk("prehit_pf_addr", req_log[n], 22'h100010);

        // Tag wrap at the top of the ROM
        pulse_flush();
        n = req_log.size();
        strobe(18'h3FFFF, exp_byte(18'h3FFFF), 1, 0);
        wait_idle("wrap");
        chk("wrap_dem_addr", req_log[n], 22'h11FFFC);
        chk("wrap_pf_addr", req_log[n+1], 22'h100000);

        // Strobe to the line being prefetched; a second strobe while busy is dropped
        pulse_flush();
        ack_lat = 20;
        n = req_log.size();
        strobe(18'h00100, exp_byte(18'h00100), 1, 0);
        for (int i = 0; i < 300 && req_log.size() < n + 2; i++) @(negedge clk);
        chk("drain_pf_seen", req_log.size() >= n + 2, 1);
        strobe(18'h0010D, exp_byte(18'h0010D), 1, 0);
        chk("drain_busy", rd_busy, 1);
        strobe(18'h00100, 8'h00, 0, 0);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_one_req", last_valid_reqs, n + 2);
        wait_idle("drain");
        chk("drain_dem_addr", req_log[n], 22'h100080);
        chk("drain_pf_addr", req_log[n+1], 22'h100084);
        chk("drain_next_pf", req_log[n+2], 22'h100088);

        // Flush while a demand is in flight: discard and reissue
        pulse_flush();
        ack_lat = 10;
        n = req_log.size();
        strobe(18'h00235, exp_byte(18'h00235), 1, 0);
        repeat (3) @(negedge clk);
        pulse_flush();
        wait_idle("flushdem");
        chk("flushdem_nreq", req_log.size(), n + 3);
        chk("flushdem_first", req_log[n], 22'h100118);
        chk("flushdem_reissue", req_log[n+1], 22'h100118);
        chk("flushdem_pf", req_log[n+2], 22'h10011C);

        // Flush coincident with a strobe that would otherwise hit CUR
        ack_lat = 3;
        n = req_log.size();
        strobe(18'h00230, exp_byte(18'h00230), 1, 1);
        wait_idle("flushstb");
        chk("flushstb_nreq", req_log.size(), n + 2);
        chk("flushstb_dem", req_log[n], 22'h100118);

        // Reset mid-fetch, then release while the controller still holds ack high
        resp_en = 1'b0;
        strobe(18'h00300, 8'h00, 0, 0);
        chk("mf_req_out", sdr_req !== sdr_ack, 1);
        @(negedge clk);
        init_n  = 1'b0;
        sdr_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("mf_rst_req", sdr_req, 0);
        chk("mf_rst_busy", rd_busy, 0);
        init_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("sync_hold_req", sdr_req, 0);
        sdr_ack = 1'b0;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("sync_release_req", sdr_req, 0);
        n = req_log.size();
        strobe(18'h00013, 8'h44, 1, 0);
        wait_idle("postsync");
        chk("postsync_nreq", req_log.size(), n + 2);
        chk("postsync_dem", req_log[n], 22'h100008);

        chk("sb_empty", exp_q.size(), 0);
        chk("valid_count", n_valid, n_acc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
